paket_verici: RTL and testbench

Parametrised packet transmitter. It accepts N-bit packets (N = W*K, K characters of W bits) through a valid/ready handshake into a small input FIFO. It sends each packet either whole in one cycle or serialised one character per cycle, MSB-first or LSB-first, and honours downstream backpressure. It is the next-generation transmitter on the final-project datapath, between the packet source and the character-level receiver.

---
 rtl/verici_pkg.sv | 18 +
 rtl/verici_fifo.sv | 64 ++++++
 rtl/paket_verici.sv | 143 ++++++++++++++
 tb/tb_paket_verici.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/verici_pkg.sv
// Shared definitions for the paket_verici packet transmitter.
// Mode encodings, engine states and index-width helper.
package verici_pkg;

    localparam logic [1:0] MOD_PARALEL = 2'b00;
    localparam logic [1:0] MOD_MSB     = 2'b01;
    localparam logic [1:0] MOD_LSB     = 2'b10;

    typedef enum logic {
        BOS,
        GONDER
    } durum_t;

    function automatic int idx_w(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/verici_fifo.sv
// Small synchronous FIFO holding {mod, packet} entries.
// Simultaneous push and pop are allowed whenever not full.
module verici_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_SON = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] sonraki(input logic [PW-1:0] p);
        return (p == PTR_SON) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= sonraki(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= sonraki(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/paket_verici.sv
// Packet transmitter: FIFO-buffered packets sent whole or
// serialised one character per cycle with backpressure.
module paket_verici
    import verici_pkg::*;
#(
    parameter int W = 3,
    parameter int K = 10,
    parameter int D = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             basla,
    input  logic [1:0]       mod,
    input  logic [W*K-1:0]   gelen_veri,
    output logic             hazir,
    input  logic             hedef_hazir,
    output logic [W*K-1:0]   cikan_veri,
    output logic             cikan_gecerli,
    output logic             bitti,
    output logic             mesgul
);

    localparam int N  = W * K;
    localparam int IW = idx_w(K);
    localparam int CW = $clog2(D + 1);
    localparam logic [IW-1:0] SON = IW'(K - 1);

    logic [N+1:0]  f_dout;
    logic          f_full;
    logic          f_empty;
    logic [CW-1:0] f_count;
    logic          pop;
    logic [1:0]    f_mod;
    logic [N-1:0]  f_veri;

    durum_t        durum, durum_n;
    logic [IW-1:0] idx, idx_n;
    logic [N-1:0]  tampon, tampon_n;
    logic          yon_lsb, yon_lsb_n;
    logic [N-1:0]  veri_n;
    logic          gecerli_n;
    logic          bitti_n;
    logic [W-1:0]  kar;
    logic          son_kar;

    verici_fifo #(
        .WIDTH (N + 2),
        .DEPTH (D)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (basla && hazir),
        .pop   (pop),
        .din   ({mod, gelen_veri}),
        .dout  (f_dout),
        .full  (f_full),
        .empty (f_empty),
        .count (f_count)
    );

    assign hazir  = !f_full;
    assign f_mod  = f_dout[N+1:N];
    assign f_veri = f_dout[N-1:0];
    assign mesgul = (durum != BOS) || (f_count != '0);

    // Serial characters always come from the latched copy.
    assign kar     = tampon[int'(idx)*W +: W];
    assign son_kar = yon_lsb ? (idx == SON) : (idx == '0);

    always_comb begin
        durum_n   = durum;
        idx_n     = idx;
        tampon_n  = tampon;
        yon_lsb_n = yon_lsb;
        veri_n    = cikan_veri;
        gecerli_n = 1'b0;
        bitti_n   = 1'b0;
        pop       = 1'b0;
        unique case (durum)
            BOS: begin
                if (!f_empty && hedef_hazir) begin
                    pop       = 1'b1;
                    gecerli_n = 1'b1;
                    if (f_mod == MOD_PARALEL) begin
                        veri_n  = f_veri;
                        bitti_n = 1'b1;
                    end else begin
                        tampon_n  = f_veri;
                        yon_lsb_n = (f_mod == MOD_LSB);
                        if (f_mod == MOD_LSB) begin
                            veri_n = N'(f_veri[W-1:0]);
                            idx_n  = IW'(1);
                        end else begin
                            veri_n = N'(f_veri[(K-1)*W +: W]);
                            idx_n  = SON - IW'(1);
                        end
                        if (K == 1) begin
                            bitti_n = 1'b1;
                        end else begin
                            durum_n = GONDER;
                        end
                    end
                end
            end
            GONDER: begin
                if (hedef_hazir) begin
                    veri_n    = N'(kar);
                    gecerli_n = 1'b1;
                    if (son_kar) begin
                        bitti_n = 1'b1;
                        durum_n = BOS;
                    end else if (yon_lsb) begin
                        idx_n = idx + IW'(1);
                    end else begin
                        idx_n = idx - IW'(1);
                    end
                end
            end
            default: durum_n = BOS;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            durum         <= BOS;
            idx           <= '0;
            tampon        <= '0;
            yon_lsb       <= 1'b0;
            cikan_veri    <= '0;
            cikan_gecerli <= 1'b0;
            bitti         <= 1'b0;
        end else begin
            durum         <= durum_n;
            idx           <= idx_n;
            tampon        <= tampon_n;
            yon_lsb       <= yon_lsb_n;
            cikan_veri    <= veri_n;
            cikan_gecerli <= gecerli_n;
            bitti         <= bitti_n;
        end
    end

endmodule

// File: tb/tb_paket_verici.sv
// Directed self-checking bench for paket_verici (W=3, K=10, D=2).
module tb_paket_verici;

    localparam int W = 3;
    localparam int K = 10;
    localparam int D = 2;
    localparam int N = W * K;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         basla = 1'b0;
    logic [1:0]   mod = 2'b00;
    logic [N-1:0] gelen_veri = '0;
    logic         hedef_hazir = 1'b1;
    logic         hazir;
    logic [N-1:0] cikan_veri;
    logic         cikan_gecerli;
    logic         bitti;
    logic         mesgul;

    int n_chk = 0;
    int n_fail = 0;

    logic [2:0] seq_msb [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    logic [2:0] seq_lsb [10] = '{1, 0, 7, 6, 5, 4, 3, 2, 1, 0};
    logic [2:0] seq_c   [10] = '{7, 6, 5, 4, 3, 2, 1, 0, 7, 6};
    logic [2:0] exp5    [30];

    localparam logic [N-1:0] DA = 30'o0123456701;
    localparam logic [N-1:0] DC = 30'o7654321076;

    paket_verici #(.W(W), .K(K), .D(D)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .basla         (basla),
        .mod           (mod),
        .gelen_veri    (gelen_veri),
        .hazir         (hazir),
        .hedef_hazir   (hedef_hazir),
        .cikan_veri    (cikan_veri),
        .cikan_gecerli (cikan_gecerli),
        .bitti         (bitti),
        .mesgul        (mesgul)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ser(input string tag, input logic [1:0] m,
                       input logic [N-1:0] d, input logic [2:0] s [10],
                       input int st_at, input int st_n);
        int k;
        k = 0;
        basla = 1'b1;
        mod = m;
        gelen_veri = d;
        tick();
        basla = 1'b0;
        gelen_veri = ~d;
        for (int c = 0; c < K + st_n; c++) begin
            hedef_hazir = !(c >= st_at && c < st_at + st_n);
            tick();
            if (hedef_hazir) begin
                chk({tag, "_veri"}, 32'(cikan_veri), 32'(s[k]));
                chk({tag, "_gec"}, 32'(cikan_gecerli), 32'd1);
                chk({tag, "_bitti"}, 32'(bitti), 32'(k == K - 1));
                k++;
            end else begin
                chk({tag, "_hold"}, 32'(cikan_veri), 32'(s[k-1]));
                chk({tag, "_stgec"}, 32'(cikan_gecerli), 32'd0);
                chk({tag, "_stbit"}, 32'(bitti), 32'd0);
            end
        end
        hedef_hazir = 1'b1;
        tick();
        chk({tag, "_idle"}, 32'(cikan_gecerli), 32'd0);
        chk({tag, "_mesgul"}, 32'(mesgul), 32'd0);
    endtask

    initial begin
        int npush;
        int stale;
        logic h;
        for (int i = 0; i < 10; i++) begin
            exp5[i]      = seq_msb[i];
            exp5[i + 10] = seq_lsb[i];
            exp5[i + 20] = seq_c[i];
        end

        #1 rst_n = 1'b0;
        #2;
        chk("rst_veri", 32'(cikan_veri), 32'd0);
        chk("rst_gec", 32'(cikan_gecerli), 32'd0);
        chk("rst_bitti", 32'(bitti), 32'd0);
        chk("rst_hazir", 32'(hazir), 32'd1);
        chk("rst_mesgul", 32'(mesgul), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // parallel packet
        basla = 1'b1;
        mod = 2'b00;
        gelen_veri = 30'h12345678;
        tick();
        basla = 1'b0;
        gelen_veri = '0;
        chk("t1_busy", 32'(mesgul), 32'd1);
        chk("t1_nogec", 32'(cikan_gecerli), 32'd0);
        tick();
        chk("t1_veri", 32'(cikan_veri), 32'h12345678);
        chk("t1_gec", 32'(cikan_gecerli), 32'd1);
        chk("t1_bitti", 32'(bitti), 32'd1);
        chk("t1_mesgul", 32'(mesgul), 32'd0);
        tick();
        chk("t1_gec2", 32'(cikan_gecerli), 32'd0);
        chk("t1_bitti2", 32'(bitti), 32'd0);
        chk("t1_hold", 32'(cikan_veri), 32'h12345678);

        ser("t2", 2'b01, DA, seq_msb, -1, 0);
        ser("t3", 2'b10, DA, seq_lsb, -1, 0);
        ser("t4", 2'b01, DA, seq_msb, 4, 3);
        ser("t11", 2'b11, DA, seq_msb, -1, 0);

        // downstream not ready while a parallel packet waits
        hedef_hazir = 1'b0;
        basla = 1'b1;
        mod = 2'b00;
        gelen_veri = 30'h0ABCDEF;
        tick();
        basla = 1'b0;
        tick();
        tick();
        chk("tw_gec", 32'(cikan_gecerli), 32'd0);
        chk("tw_mesgul", 32'(mesgul), 32'd1);
        hedef_hazir = 1'b1;
        tick();
        chk("tw_veri", 32'(cikan_veri), 32'h0ABCDEF);
        chk("tw_bitti", 32'(bitti), 32'd1);
        tick();

        // three back-to-back serial packets through a 2-deep FIFO
        npush = 0;
        basla = 1'b1;
        mod = 2'b01;
        gelen_veri = DA;
        for (int c = 0; c <= 30; c++) begin
            h = hazir;
            tick();
            if (basla && h) npush++;
            if (c == 0) chk("t5_h0", 32'(hazir), 32'd1);
            if (c == 2) chk("t5_full", 32'(hazir), 32'd0);
            if (c == 11) chk("t5_back", 32'(hazir), 32'd1);
            if (c >= 1) begin
                chk("t5_veri", 32'(cikan_veri), 32'(exp5[c-1]));
                chk("t5_gec", 32'(cikan_gecerli), 32'd1);
                chk("t5_bitti", 32'(bitti), 32'((c - 1) % 10 == 9));
            end
            basla = (npush < 3);
            if (npush == 1) begin
                mod = 2'b10;
                gelen_veri = DA;
            end else if (npush == 2) begin
                mod = 2'b01;
                gelen_veri = DC;
            end
        end
        chk("t5_npush", 32'(npush), 32'd3);
        tick();
        chk("t5_mesgul", 32'(mesgul), 32'd0);

        // asynchronous reset mid-packet with one packet queued
        basla = 1'b1;
        mod = 2'b01;
        gelen_veri = DA;
        tick();
        gelen_veri = DC;
        tick();
        basla = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("t6_5th", 32'(cikan_veri), 32'd4);
        chk("t6_busy", 32'(mesgul), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_veri", 32'(cikan_veri), 32'd0);
        chk("t6_gec", 32'(cikan_gecerli), 32'd0);
        chk("t6_bitti", 32'(bitti), 32'd0);
        chk("t6_hazir", 32'(hazir), 32'd1);
        chk("t6_mesgul", 32'(mesgul), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (cikan_gecerli) stale++;
        end
        chk("t6_stale", 32'(stale), 32'd0);
        chk("t6_hazir2", 32'(hazir), 32'd1);
        chk("t6_mesgul2", 32'(mesgul), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
